accel_op_sequencer: RTL and testbench



---
 rtl/accel_op_sequencer.sv | 236 +++++++++++++++++++++++
 tb/tb_accel_op_sequencer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/accel_op_sequencer.sv
`default_nettype none
// ============================================================================
// accel_op_sequencer : queued 8-bit ALU command sequencer with result FIFO
// Rev 1.0
// ============================================================================
module accel_op_sequencer #(
  parameter int CMD_DEPTH = 4,
  parameter int RES_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] address,
  input  logic       data_write,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       busy,
  output logic       irq
);

  localparam int CMD_PTR_W = $clog2(CMD_DEPTH);
  localparam int RES_PTR_W = $clog2(RES_DEPTH);
  localparam int CMD_CNT_W = $clog2(CMD_DEPTH + 1);
  localparam int RES_CNT_W = $clog2(RES_DEPTH + 1);

  localparam logic [3:0] ADDR_OPA    = 4'h0;
  localparam logic [3:0] ADDR_OPB    = 4'h1;
  localparam logic [3:0] ADDR_CMD    = 4'h2;
  localparam logic [3:0] ADDR_STATUS = 4'h3;
  localparam logic [3:0] ADDR_RES_LO = 4'h5;
  localparam logic [3:0] ADDR_RES_HI = 4'h6;
  localparam logic [3:0] ADDR_POP    = 4'h7;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_WB   = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [7:0]  opa_q, opb_q;
  logic [7:0]  a_q, a_d, b_q, b_d;
  logic [2:0]  op_q, op_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] acc_q, acc_d;
  logic        ovf_q, ovf_d, div0_q, div0_d;

  logic [18:0]          cmd_mem_q [CMD_DEPTH];
  logic [CMD_PTR_W-1:0] cmd_rd_q, cmd_wr_q;
  logic [CMD_CNT_W-1:0] cmd_cnt_q, cmd_cnt_d;
  logic [15:0]          res_mem_q [RES_DEPTH];
  logic [RES_PTR_W-1:0] res_rd_q, res_wr_q;
  logic [RES_CNT_W-1:0] res_cnt_q, res_cnt_d;

  logic w_wr_opa, w_wr_opb, w_wr_cmd, w_wr_status, w_wr_pop;
  logic w_cmd_full, w_cmd_empty, w_res_full, w_res_empty;
  logic w_cmd_push, w_res_pop;
  logic w_dispatch, w_res_push, w_exec_last, w_single;
  logic [18:0] w_cmd_head;
  logic [15:0] w_res_head;
  logic [15:0] w_alu_single, w_mul_step, w_div_step, w_addend;
  logic [8:0]  w_sum9, w_rem_shift, w_rem_sub;
  logic [7:0]  w_rem_next;
  logic        w_ge;

  assign w_wr_opa    = data_write && (address == ADDR_OPA);
  assign w_wr_opb    = data_write && (address == ADDR_OPB);
  assign w_wr_cmd    = data_write && (address == ADDR_CMD);
  assign w_wr_status = data_write && (address == ADDR_STATUS);
  assign w_wr_pop    = data_write && (address == ADDR_POP);

  assign w_cmd_full  = (cmd_cnt_q == CMD_CNT_W'(CMD_DEPTH));
  assign w_cmd_empty = (cmd_cnt_q == '0);
  assign w_res_full  = (res_cnt_q == RES_CNT_W'(RES_DEPTH));
  assign w_res_empty = (res_cnt_q == '0);
  assign w_cmd_head  = cmd_mem_q[cmd_rd_q];
  assign w_res_head  = res_mem_q[res_rd_q];

  // A full queue still accepts a write when the dispatcher frees a slot on the same edge.
  assign w_cmd_push = w_wr_cmd && (!w_cmd_full || w_dispatch);
  assign w_res_pop  = w_wr_pop && !w_res_empty;

  assign w_single = !((op_q == OP_MUL) || ((op_q == OP_DIV) && (b_q != 8'h00)));

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (!w_cmd_empty && !w_res_full) state_d = S_EXEC;
      S_EXEC:  if (w_single || (cnt_q == 3'd7)) state_d = S_WB;
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    w_dispatch  = 1'b0;
    w_exec_last = 1'b0;
    w_res_push  = 1'b0;
    case (state_q)
      S_IDLE:  w_dispatch  = !w_cmd_empty && !w_res_full;
      S_EXEC:  w_exec_last = w_single || (cnt_q == 3'd7);
      S_WB:    w_res_push  = 1'b1;
      default: ;
    endcase
  end

  // ---------------- ALU ----------------
  assign w_sum9 = {1'b0, a_q} + {1'b0, b_q};

  always_comb begin
    case (op_q)
      OP_ADD:  w_alu_single = {7'h00, w_sum9};
      OP_SUB:  w_alu_single = {8'h00, a_q} - {8'h00, b_q};
      OP_DIV:  w_alu_single = {a_q, 8'hFF};
      OP_AND:  w_alu_single = {8'h00, a_q & b_q};
      OP_OR:   w_alu_single = {8'h00, a_q | b_q};
      OP_XOR:  w_alu_single = {8'h00, a_q ^ b_q};
      default: w_alu_single = 16'h0000;
    endcase
  end

  assign w_addend   = b_q[cnt_q] ? ({8'h00, a_q} << cnt_q) : 16'h0000;
  assign w_mul_step = acc_q + w_addend;

  // Divide keeps {remainder, dividend/quotient} in acc; the quotient bit shifts in at the LSB.
  assign w_rem_shift = {acc_q[15:8], acc_q[7]};
  assign w_ge        = (w_rem_shift >= {1'b0, b_q});
  assign w_rem_sub   = w_rem_shift - {1'b0, b_q};
  assign w_rem_next  = w_ge ? w_rem_sub[7:0] : w_rem_shift[7:0];
  assign w_div_step  = {w_rem_next, acc_q[6:0], w_ge};

  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    op_d   = op_q;
    cnt_d  = cnt_q;
    acc_d  = acc_q;
    ovf_d  = ovf_q;
    div0_d = div0_q;
    if (w_wr_status) begin
      ovf_d  = 1'b0;
      div0_d = 1'b0;
    end
    if (w_wr_cmd && w_cmd_full && !w_dispatch) ovf_d = 1'b1;
    if (w_dispatch) begin
      op_d  = w_cmd_head[18:16];
      a_d   = w_cmd_head[15:8];
      b_d   = w_cmd_head[7:0];
      cnt_d = 3'd0;
      acc_d = (w_cmd_head[18:16] == OP_DIV) ? {8'h00, w_cmd_head[15:8]} : 16'h0000;
    end else if (state_q == S_EXEC) begin
      if (w_single) begin
        acc_d = w_alu_single;
        if (op_q == OP_DIV) div0_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 3'd1;
        acc_d = (op_q == OP_MUL) ? w_mul_step : w_div_step;
      end
    end
  end

  assign cmd_cnt_d = cmd_cnt_q + CMD_CNT_W'(w_cmd_push) - CMD_CNT_W'(w_dispatch);
  assign res_cnt_d = res_cnt_q + RES_CNT_W'(w_res_push) - RES_CNT_W'(w_res_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opa_q     <= 8'h00;
      opb_q     <= 8'h00;
      a_q       <= 8'h00;
      b_q       <= 8'h00;
      op_q      <= 3'b000;
      cnt_q     <= 3'd0;
      acc_q     <= 16'h0000;
      ovf_q     <= 1'b0;
      div0_q    <= 1'b0;
      cmd_rd_q  <= '0;
      cmd_wr_q  <= '0;
      cmd_cnt_q <= '0;
      res_rd_q  <= '0;
      res_wr_q  <= '0;
      res_cnt_q <= '0;
    end else begin
      if (w_wr_opa) opa_q <= data_in;
      if (w_wr_opb) opb_q <= data_in;
      a_q       <= a_d;
      b_q       <= b_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      ovf_q     <= ovf_d;
      div0_q    <= div0_d;
      cmd_cnt_q <= cmd_cnt_d;
      res_cnt_q <= res_cnt_d;
      if (w_cmd_push) cmd_wr_q <= cmd_wr_q + CMD_PTR_W'(1);
      if (w_dispatch) cmd_rd_q <= cmd_rd_q + CMD_PTR_W'(1);
      if (w_res_push) res_wr_q <= res_wr_q + RES_PTR_W'(1);
      if (w_res_pop)  res_rd_q <= res_rd_q + RES_PTR_W'(1);
    end
  end

  // Storage needs no reset: occupancy counters decide what is visible.
  always_ff @(posedge clk) begin
    if (w_cmd_push) cmd_mem_q[cmd_wr_q] <= {data_in[2:0], opa_q, opb_q};
    if (w_res_push) res_mem_q[res_wr_q] <= acc_q;
  end

  assign busy = (state_q != S_IDLE) || !w_cmd_empty;
  assign irq  = !w_res_empty;

  always_comb begin
    case (address)
      ADDR_OPA:    data_out = opa_q;
      ADDR_OPB:    data_out = opb_q;
      ADDR_STATUS: data_out = {1'b0, div0_q, ovf_q, w_res_full, !w_res_empty,
                               w_cmd_empty, w_cmd_full, busy};
      ADDR_RES_LO: data_out = w_res_empty ? 8'h00 : w_res_head[7:0];
      ADDR_RES_HI: data_out = w_res_empty ? 8'h00 : w_res_head[15:8];
      default:     data_out = 8'h00;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_accel_op_sequencer.sv
`default_nettype none
// ============================================================================
// tb_accel_op_sequencer : directed + randomized checks against a reference model
// Rev 1.0
// ============================================================================
module tb_accel_op_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] address;
  logic       data_write;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       busy;
  logic       irq;

  int n_assert = 0;
  int n_fail   = 0;

  accel_op_sequencer #(.CMD_DEPTH(4), .RES_DEPTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .address    (address),
    .data_write (data_write),
    .data_in    (data_in),
    .data_out   (data_out),
    .busy       (busy),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    int ia = int'(a);
    int ib = int'(b);
    case (op)
      3'd0: return 16'(ia + ib);
      3'd1: return 16'(ia - ib);
      3'd2: return 16'(ia * ib);
      3'd3: return (ib == 0) ? {a, 8'hFF} : {8'(ia % ib), 8'(ia / ib)};
      3'd4: return 16'(ia & ib);
      3'd5: return 16'(ia | ib);
      3'd6: return 16'(ia ^ ib);
      default: return 16'h0000;
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] op, input logic [7:0] b);
    return (op == 3'd2 || (op == 3'd3 && b != 8'h00)) ? 10 : 3;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    address = a; data_in = d; data_write = 1'b1;
    @(posedge clk);
    #1 data_write = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [7:0] v);
    address = a;
    #1 v = data_out;
  endtask

  task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    wr(4'h0, a);
    wr(4'h1, b);
    wr(4'h2, {5'b0, op});
  endtask

  // Cycles from the CMD write edge until irq is seen; 40 means it never came.
  task automatic wait_irq(output int n);
    n = 0;
    while (n < 40) begin
      @(posedge clk);
      #1 n++;
      if (irq) break;
    end
  endtask

  task automatic read_res(output logic [15:0] r);
    logic [7:0] lo, hi;
    rd(4'h5, lo);
    rd(4'h6, hi);
    r = {hi, lo};
  endtask

  initial begin
    logic [7:0]  v;
    logic [15:0] r;
    logic [15:0] exp_q[$];
    logic [2:0]  op;
    logic [7:0]  a, b;
    int          n;

    rst_n = 1'b0; address = 4'h0; data_write = 1'b0; data_in = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_irq", irq, 0);
    rd(4'h3, v); chk("reset_status", v, 8'h04);
    @(negedge clk) rst_n = 1'b1;

    // 1: ADD
    issue(3'd0, 8'hC8, 8'h64);
    wait_irq(n); chk("add_latency", n, 3);
    read_res(r); chk("add_result", r, 16'h012C);
    wr(4'h7, 8'h00);
    chk("add_pop_irq", irq, 0);
    rd(4'h3, v); chk("add_pop_status", v, 8'h04);
    rd(4'h5, v); chk("empty_res_lo", v, 8'h00);

    // 2: MUL
    issue(3'd2, 8'hFF, 8'hFF);
    chk("mul_busy_start", busy, 1);
    wait_irq(n); chk("mul_latency", n, 10);
    chk("mul_busy_end", busy, 0);
    read_res(r); chk("mul_result", r, 16'hFE01);
    wr(4'h7, 8'h00);

    // 3: DIV and divide by zero
    issue(3'd3, 8'h64, 8'h07);
    wait_irq(n); chk("div_latency", n, 10);
    read_res(r); chk("div_result", r, 16'h020E);
    wr(4'h7, 8'h00);
    issue(3'd3, 8'h2A, 8'h00);
    wait_irq(n); chk("div0_latency", n, 3);
    read_res(r); chk("div0_result", r, 16'h2AFF);
    rd(4'h3, v); chk("div0_status", v, 8'h4C);
    wr(4'h7, 8'h00);
    wr(4'h3, 8'h00);
    rd(4'h3, v); chk("div0_cleared", v, 8'h04);

    // 4: SUB, XOR, opcode 111
    issue(3'd1, 8'h03, 8'h05);
    wait_irq(n); read_res(r); chk("sub_result", r, 16'hFFFE); wr(4'h7, 8'h00);
    issue(3'd6, 8'hF0, 8'h3C);
    wait_irq(n); read_res(r); chk("xor_result", r, 16'h00CC); wr(4'h7, 8'h00);
    issue(3'd7, 8'h55, 8'hAA);
    wait_irq(n); chk("op7_latency", n, 3);
    read_res(r); chk("op7_result", r, 16'h0000); wr(4'h7, 8'h00);

    // 5: fill both FIFOs, overflow, drain in order
    for (int i = 1; i <= 9; i++) begin
      issue(3'd0, 8'(i), 8'h01);
      repeat (20) @(posedge clk);
      #1;
      if (i == 4) begin rd(4'h3, v); chk("res_full_status", v, 8'h1C); end
    end
    rd(4'h3, v); chk("overflow_status", v, 8'h3B);
    for (int i = 1; i <= 8; i++) begin
      read_res(r); chk($sformatf("drain_%0d", i), r, 16'(i + 1));
      wr(4'h7, 8'h00);
      repeat (6) @(posedge clk);
      #1;
    end
    rd(4'h3, v); chk("drained_status", v, 8'h24);
    wr(4'h3, 8'h00);

    // 6: asynchronous reset mid-EXEC
    issue(3'd2, 8'h12, 8'h34);
    repeat (3) @(posedge clk);
    #2;
    chk("pre_reset_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_irq", irq, 0);
    rd(4'h3, v); chk("rst_status", v, 8'h04);
    rd(4'h0, v); chk("rst_opa", v, 8'h00);
    rd(4'h1, v); chk("rst_opb", v, 8'h00);
    @(negedge clk) rst_n = 1'b1;
    issue(3'd0, 8'h01, 8'h01);
    wait_irq(n); chk("post_rst_latency", n, 3);
    read_res(r); chk("post_rst_result", r, 16'h0002);
    wr(4'h7, 8'h00);

    // Randomized single commands against the model
    for (int i = 0; i < 24; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = 8'($urandom);
      b  = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      issue(op, a, b);
      wait_irq(n); chk($sformatf("rnd_lat_%0d", i), n, model_lat(op, b));
      read_res(r); chk($sformatf("rnd_res_%0d op%0d", i, op), r, model(op, a, b));
      rd(4'h3, v); chk($sformatf("rnd_div0_%0d", i), v[6], (op == 3'd3 && b == 8'h00));
      wr(4'h7, 8'h00);
      wr(4'h3, 8'h00);
    end

    // Randomized bursts: ordering through the queues
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 4; i++) begin
        op = 3'($urandom_range(0, 7));
        a  = 8'($urandom);
        b  = 8'($urandom);
        issue(op, a, b);
        exp_q.push_back(model(op, a, b));
      end
      repeat (60) @(posedge clk);
      #1;
      while (exp_q.size() > 0) begin
        read_res(r); chk($sformatf("burst_%0d", k), r, exp_q.pop_front());
        wr(4'h7, 8'h00);
      end
      chk($sformatf("burst_empty_%0d", k), irq, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
